// File: rtl/ram_banked.sv
// ram_banked: single-port lane-banked RAM with valid/ready channels.
// Synchronous read feeds a 2-entry response FIFO; optional write acks.
module ram_banked #(
  parameter int NUM_BANKS  = 4,
  parameter int BANK_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int WRITE_ACK  = 0
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_we,
  input  logic [NUM_BANKS-1:0]            req_be,
  input  logic [ADDR_WIDTH-1:0]           req_addr,
  input  logic [NUM_BANKS*BANK_WIDTH-1:0] req_wdata,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_we,
  output logic [NUM_BANKS*BANK_WIDTH-1:0] rsp_rdata
);

  localparam int DW    = NUM_BANKS * BANK_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DW-1:0]        mem [DEPTH];
  logic [DW-1:0]        rd_raw;
  logic [NUM_BANKS-1:0] be_q;
  logic                 we_q;
  logic                 inflight;

  logic [DW-1:0]        fifo_d [2];
  logic [1:0]           fifo_w;
  logic                 rd_ptr;
  logic                 wr_ptr;
  logic [1:0]           count;

  logic                 accept;
  logic                 need_rsp;
  logic                 pop;
  logic                 push_f;
  logic                 pop_f;
  logic [DW-1:0]        lane_mask;
  logic [DW-1:0]        stage_d;
  logic [DW-1:0]        head_d;
  logic                 head_we;
  logic [2:0]           level;

  assign accept   = req_valid & req_ready;
  assign need_rsp = accept & (~req_we | (WRITE_ACK != 0));

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < NUM_BANKS; i++)
      lane_mask[i*BANK_WIDTH +: BANK_WIDTH] = {BANK_WIDTH{be_q[i]}};
  end

  assign stage_d = rd_raw & lane_mask;

  // The staged read bypasses the FIFO when it is empty: 1-cycle latency.
  assign head_d  = (count != 2'd0) ? fifo_d[rd_ptr] : stage_d;
  assign head_we = (count != 2'd0) ? fifo_w[rd_ptr] : we_q;

  assign rsp_valid = (count != 2'd0) | inflight;
  assign rsp_rdata = rsp_valid ? head_d : '0;
  assign rsp_we    = rsp_valid & head_we;

  assign pop    = rsp_valid & rsp_ready;
  assign pop_f  = pop & (count != 2'd0);
  assign push_f = inflight & ~(pop & (count == 2'd0));

  assign level = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign req_ready = reset_n & (level < 3'd2);

  // Array and FIFO storage carry no reset; contents persist.
  always_ff @(posedge clock) begin
    if (accept && req_we) begin
      for (int i = 0; i < NUM_BANKS; i++)
        if (req_be[i])
          mem[req_addr][i*BANK_WIDTH +: BANK_WIDTH] <=
            req_wdata[i*BANK_WIDTH +: BANK_WIDTH];
    end
    if (need_rsp)
      rd_raw <= mem[req_addr];
    if (push_f) begin
      fifo_d[wr_ptr] <= stage_d;
      fifo_w[wr_ptr] <= we_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight <= 1'b0;
      be_q     <= '0;
      we_q     <= 1'b0;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      inflight <= need_rsp;
      if (need_rsp) begin
        be_q <= req_be;
        we_q <= req_we;
      end
      if (push_f)
        wr_ptr <= ~wr_ptr;
      if (pop_f)
        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push_f} - {1'b0, pop_f};
    end
  end

endmodule

// File: tb/tb_ram_banked.sv
// tb_ram_banked: scoreboard bench for ram_banked, one instance per
// WRITE_ACK setting, exercised one at a time against a word model.
module tb_ram_banked;

  localparam int NB = 4;
  localparam int BW = 8;
  localparam int AW = 10;
  localparam int DW = NB * BW;

  typedef struct packed {
    logic          we;
    logic          chk;
    logic [DW-1:0] d;
  } rsp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  logic          req_valid [2];
  logic          req_ready [2];
  logic          req_we    [2];
  logic [NB-1:0] req_be    [2];
  logic [AW-1:0] req_addr  [2];
  logic [DW-1:0] req_wdata [2];
  logic          rsp_valid [2];
  logic          rsp_ready [2];
  logic          rsp_we    [2];
  logic [DW-1:0] rsp_rdata [2];

  ram_banked #(.NUM_BANKS(NB), .BANK_WIDTH(BW), .ADDR_WIDTH(AW),
               .WRITE_ACK(0)) u0 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_be(req_be[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_we(rsp_we[0]), .rsp_rdata(rsp_rdata[0])
  );

  ram_banked #(.NUM_BANKS(NB), .BANK_WIDTH(BW), .ADDR_WIDTH(AW),
               .WRITE_ACK(1)) u1 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_be(req_be[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_we(rsp_we[1]), .rsp_rdata(rsp_rdata[1])
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cur = 0;
  int last_acc = 0;
  logic rnd_bp = 1'b0;

  logic [DW-1:0] mdl [2][1024];
  rsp_t sb[$];
  int pop_cyc[$];

  logic          stall = 1'b0;
  logic [DW-1:0] stall_d;
  logic          stall_we;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] lmask(input logic [NB-1:0] be);
    logic [DW-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) m[i*BW +: BW] = {BW{be[i]}};
    return m;
  endfunction

  // Monitor: pops the scoreboard on every handshake of the active DUT.
  always @(negedge clock) begin
    rsp_t e;
    if (!reset_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("hold_valid", rsp_valid[cur], 1);
        check("hold_data", rsp_rdata[cur], stall_d);
        check("hold_we", rsp_we[cur], stall_we);
      end
      if (rsp_valid[cur] && rsp_ready[cur]) begin
        pop_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp: got %h expected none",
                   rsp_rdata[cur]);
        end else begin
          e = sb.pop_front();
          check("rsp_we", rsp_we[cur], e.we);
          if (e.chk) check("rsp_rdata", rsp_rdata[cur], e.d);
        end
      end
      stall    = rsp_valid[cur] && !rsp_ready[cur];
      stall_d  = rsp_rdata[cur];
      stall_we = rsp_we[cur];
    end
  end

  always @(posedge clock) begin
    #1;
    if (rnd_bp) rsp_ready[cur] = 1'($urandom_range(0, 1));
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Must be entered just after a rising edge; returns just after the
  // accepting edge with req_valid still high.
  task automatic issue(input logic we, input logic [NB-1:0] be,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic chk, output int waits);
    logic [DW-1:0] old;
    logic [DW-1:0] m;
    logic ok;
    req_valid[cur] = 1'b1;
    req_we[cur]    = we;
    req_be[cur]    = be;
    req_addr[cur]  = a;
    req_wdata[cur] = wd;
    waits = 0;
    ok = 1'b0;
    while (!ok && waits <= 200) begin
      @(negedge clock);
      if (req_ready[cur]) ok = 1'b1;
      else begin
        waits++;
        step();
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got %0d waits expected <=200", waits);
      req_valid[cur] = 1'b0;
    end else begin
      last_acc = cyc;
      old = mdl[cur][a];
      m = lmask(be);
      if (!we || cur == 1)
        sb.push_back('{we: we, chk: chk, d: old & m});
      if (we) mdl[cur][a] = (old & ~m) | (wd & m);
      step();
    end
  endtask

  task automatic idle();
    req_valid[cur] = 1'b0;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    rnd_bp = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clock);
      #2;
      rsp_ready[cur] = 1'b1;
      @(negedge clock);
      if (sb.size() == 0 && !rsp_valid[cur]) done = 1'b1;
    end
    check("drain", done, 1);
    step();
  endtask

  task automatic fill(input logic chk);
    int w;
    for (int a = 0; a < 64; a++)
      issue(1'b1, 4'hF, AW'(a), $urandom, chk, w);
    issue(1'b1, 4'hF, 10'h3FF, $urandom, chk, w);
    idle();
    drain();
  endtask

  task automatic random_ops(input int n);
    int w;
    logic [AW-1:0] a;
    rnd_bp = 1'b1;
    for (int i = 0; i < n; i++) begin
      a = ($urandom_range(0, 15) == 0) ? 10'h3FF : AW'($urandom_range(0, 63));
      issue(($urandom_range(0, 2) == 0), NB'($urandom), a, $urandom, 1'b1, w);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        step();
      end
    end
    idle();
    drain();
  endtask

  initial begin
    int w;
    int first;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b1;
      req_we[d]    = 1'b0;
      req_be[d]    = '0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      rsp_ready[d] = 1'b0;
    end

    repeat (2) @(posedge clock);
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      check("rst_req_ready", req_ready[d], 0);
      check("rst_rsp_valid", rsp_valid[d], 0);
      check("rst_rsp_rdata", rsp_rdata[d], 0);
      check("rst_rsp_we", rsp_we[d], 0);
      req_valid[d] = 1'b0;
    end
    step();
    reset_n = 1'b1;
    @(negedge clock);
    for (int d = 0; d < 2; d++) check("rel_req_ready", req_ready[d], 1);
    step();

    cur = 0;
    rsp_ready[0] = 1'b1;
    fill(1'b0);

    issue(1'b1, 4'hF, 10'h005, 32'hDEADBEEF, 1'b1, w);
    issue(1'b1, 4'b0010, 10'h005, 32'h00001200, 1'b1, w);
    issue(1'b0, 4'hF, 10'h005, '0, 1'b1, w);
    idle();
    @(negedge clock);
    check("lane_valid", rsp_valid[0], 1);
    check("lane_rdata", rsp_rdata[0], 32'hDEAD12EF);
    step();
    issue(1'b0, 4'b0101, 10'h005, '0, 1'b1, w);
    idle();
    @(negedge clock);
    check("mask_rdata", rsp_rdata[0], 32'h00AD00EF);
    step();
    drain();

    rsp_ready[0] = 1'b0;
    issue(1'b0, 4'hF, 10'd1, '0, 1'b1, w);
    check("bp_waits1", w, 0);
    issue(1'b0, 4'hF, 10'd2, '0, 1'b1, w);
    check("bp_waits2", w, 0);
    req_addr[0] = 10'd3;
    repeat (3) begin
      @(negedge clock);
      check("bp_ready_low", req_ready[0], 0);
    end
    step();
    rsp_ready[0] = 1'b1;
    issue(1'b0, 4'hF, 10'd3, '0, 1'b1, w);
    check("bp_waits3", w, 0);
    idle();
    drain();

    pop_cyc.delete();
    first = 0;
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, 4'hF, AW'(i), '0, 1'b1, w);
      check("tp_waits", w, 0);
      if (i == 0) first = last_acc;
    end
    idle();
    drain();
    check("tp_count", pop_cyc.size(), 8);
    for (int i = 0; i < 8 && i < pop_cyc.size(); i++)
      check("tp_cycle", pop_cyc[i], first + 1 + i);

    rsp_ready[0] = 1'b0;
    issue(1'b1, 4'hF, 10'd40, 32'hCAFEF00D, 1'b1, w);
    issue(1'b0, 4'hF, 10'd41, '0, 1'b1, w);
    issue(1'b0, 4'hF, 10'd40, '0, 1'b1, w);
    idle();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", rsp_valid[0], 0);
    check("mid_rst_ready", req_ready[0], 0);
    sb.delete();
    step();
    reset_n = 1'b1;
    @(negedge clock);
    check("mid_rel_ready", req_ready[0], 1);
    step();
    rsp_ready[0] = 1'b1;
    issue(1'b0, 4'hF, 10'd40, '0, 1'b1, w);
    idle();
    @(negedge clock);
    check("mid_persist", rsp_rdata[0], 32'hCAFEF00D);
    step();
    drain();

    random_ops(300);

    cur = 1;
    rsp_ready[1] = 1'b1;
    fill(1'b0);

    issue(1'b1, 4'hF, 10'h010, 32'h11223344, 1'b1, w);
    idle();
    drain();
    issue(1'b1, 4'b1100, 10'h010, 32'hAABB0000, 1'b1, w);
    idle();
    @(negedge clock);
    check("ack_valid", rsp_valid[1], 1);
    check("ack_we", rsp_we[1], 1);
    check("ack_old", rsp_rdata[1], 32'h11220000);
    step();
    issue(1'b0, 4'hF, 10'h010, '0, 1'b1, w);
    idle();
    @(negedge clock);
    check("ack_new", rsp_rdata[1], 32'hAABB3344);
    step();
    issue(1'b1, 4'b0000, 10'h011, 32'hFFFFFFFF, 1'b1, w);
    idle();
    @(negedge clock);
    check("ack_be0_we", rsp_we[1], 1);
    check("ack_be0_data", rsp_rdata[1], 0);
    step();
    drain();

    random_ops(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_banked.md
Name: ram_banked

Overview:
- Single-port, byte-lane banked RAM; parametrised successor to the fixed 4x8-bit, 1K-deep data RAM.
- NUM_BANKS lanes of BANK_WIDTH bits, depth 2**ADDR_WIDTH, per-lane enables on reads and writes.
- Valid/ready request and response channels; a 2-entry response buffer absorbs backpressure without losing read data.
- Sits between the CPU load/store unit and memory; optional write acknowledge with old-data return supports swap-style accesses.

Parameters:
- NUM_BANKS, 4: number of byte lanes.
- BANK_WIDTH, 8: bits per lane.
- ADDR_WIDTH, 10: word address width; depth = 2**ADDR_WIDTH words.
- WRITE_ACK, 0: 0 = writes produce no response; 1 = writes produce a response carrying pre-write data.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready at the clock edge.
- req_we  in  1  1 = write, 0 = read.
- req_be  in  NUM_BANKS  lane enables.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  NUM_BANKS*BANK_WIDTH  write data; lane i is bits [i*BANK_WIDTH +: BANK_WIDTH].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_we  out  1  response belongs to a write (WRITE_ACK=1 only; otherwise 0).
- rsp_rdata  out  NUM_BANKS*BANK_WIDTH  read data.

Behaviour:
- Reset, asynchronous: response FIFO emptied, in-flight flag cleared, rsp_valid=0, rsp_we=0, rsp_rdata=0.
- req_ready=0 while reset_n=0.
- Memory array is not reset; contents persist across reset.
- Accepted write: lanes with req_be[i]=1 are written at the accepting edge. Lanes with req_be[i]=0 are untouched.
- req_be=0 write: no-op on the array, but still acknowledged when WRITE_ACK=1.
- Accepted read, or accepted write with WRITE_ACK=1: array read at the accepting edge T, in-flight flag set.
  - Data enters the FIFO at T+1; rsp_valid first visible in cycle T+1 (1-cycle latency when the FIFO is empty).
  - Lanes with req_be[i]=0 return 0.
  - Write acks return pre-write (old) contents of enabled lanes.
- Response FIFO:
  - Depth 2, in order, holds rdata and the we flag.
  - Head drives rsp_rdata/rsp_we; rsp_valid = FIFO not empty.
  - Output stable while rsp_valid=1 and rsp_ready=0.
- req_ready = (occupancy + inflight - pop) < 2, where pop = rsp_valid & rsp_ready.
  - Combinational path from rsp_ready to req_ready is intended.
  - Guarantees no FIFO overflow and sustains 1 access/cycle when rsp_ready is held at 1.
- Writes with WRITE_ACK=0 bypass the FIFO and are accepted whenever req_ready=1.
- Simultaneous push and pop on a full FIFO cannot occur (prevented by req_ready). Push and pop on an occupancy-1 FIFO leaves occupancy at 1.
- Back-to-back write then read of the same address: the read returns the new data.
- Address wraps naturally; no out-of-range condition.
- Reset asserted mid-operation:
  - In-flight read and buffered responses are discarded.
  - A write accepted on an edge before reset assertion has completed.
  - After reset_n rises, req_ready=1 on the first cycle.
- req_* inputs are ignored when req_valid=0. rsp_ready is ignored when rsp_valid=0.

Test Plan:
- Reset: assert reset_n=0 with req_valid=1 -> req_ready=0, rsp_valid=0, rsp_rdata=0; release -> req_ready=1 next cycle.
- Lane write/read: write addr 0x005, be=4'b1111, data 0xDEADBEEF; then write be=4'b0010, data 0x00001200; read be=4'b1111 -> rsp_rdata=0xDEAD12EF one cycle after acceptance.
- Masked read: read addr 0x005 with be=4'b0101 -> rsp_rdata=0x00AD00EF.
- Backpressure: hold rsp_ready=0 and issue 3 reads (addrs 1,2,3) -> only 2 accepted, req_ready drops. Raise rsp_ready -> responses in order with no loss, then third read accepted.
- Throughput: rsp_ready=1, 8 consecutive reads at addrs 0..7 -> req_ready stays 1 and rsp_valid is high for 8 consecutive cycles starting 1 cycle after the first accept.
- WRITE_ACK=1: addr 0x010 holds 0x11223344; write be=4'b1100, data 0xAABB0000 -> rsp_we=1, rsp_rdata=0x11220000; subsequent read -> 0xAABB3344.
